// File: rtl/coil_sys_reset_sequencer.sv
// Stretches the CPU software reset request into a clean active-low pulse
// for the coil-driver datapath, with power-on stretch and post-release holdoff.
module coil_sys_reset_sequencer #(
    parameter int ASSERT_CYCLES  = 1000,
    parameter int HOLDOFF_CYCLES = 100,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sw_reset_req,
    output logic       sys_reset_n,
    output logic       busy,
    output logic [7:0] seq_count
);

    localparam int MAX_CYCLES =
        (ASSERT_CYCLES > HOLDOFF_CYCLES) ? ASSERT_CYCLES : HOLDOFF_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] ASSERT_LAST  = CW'(ASSERT_CYCLES - 1);
    localparam logic [CW-1:0] HOLDOFF_LAST = CW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_n;
    logic                   pending;
    logic                   pending_n;
    logic                   sw_seq;
    logic                   sw_seq_n;
    logic [7:0]             count_n;
    logic                   srn_n;
    logic                   busy_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_d;
    logic                   req_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync   <= '0;
            sync_d <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], sw_reset_req};
            sync_d <= sync[SYNC_STAGES-1];
        end
    end

    assign req_edge = sync[SYNC_STAGES-1] & ~sync_d;

    // sw_seq marks whether the running ASSERT was software-triggered,
    // so the power-on stretch is excluded from seq_count.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pending_n = pending;
        sw_seq_n  = sw_seq;
        count_n   = seq_count;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (req_edge) begin
                    state_n  = ASSERT;
                    sw_seq_n = 1'b1;
                end
            end
            ASSERT: begin
                if (req_edge)
                    pending_n = 1'b1;
                if (cnt == ASSERT_LAST) begin
                    state_n = HOLDOFF;
                    cnt_n   = '0;
                    if (sw_seq && seq_count != 8'hFF)
                        count_n = seq_count + 8'd1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            HOLDOFF: begin
                if (cnt == HOLDOFF_LAST) begin
                    cnt_n = '0;
                    // an edge on the exit cycle starts the next sequence directly
                    if (pending || req_edge) begin
                        state_n   = ASSERT;
                        pending_n = 1'b0;
                        sw_seq_n  = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                    if (req_edge)
                        pending_n = 1'b1;
                end
            end
            default: begin
                state_n   = IDLE;
                cnt_n     = '0;
                pending_n = 1'b0;
            end
        endcase
        srn_n  = (state_n != ASSERT);
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ASSERT;
            cnt         <= '0;
            pending     <= 1'b0;
            sw_seq      <= 1'b0;
            seq_count   <= 8'd0;
            sys_reset_n <= 1'b0;
            busy        <= 1'b1;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            pending     <= pending_n;
            sw_seq      <= sw_seq_n;
            seq_count   <= count_n;
            sys_reset_n <= srn_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_coil_sys_reset_sequencer.sv
// Bench for coil_sys_reset_sequencer: vector table, corner sequences,
// and random traffic against a countdown-based reference model.
module tb_coil_sys_reset_sequencer;

    localparam int A = 8;
    localparam int H = 4;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sw_reset_req;
    logic       sys_reset_n;
    logic       busy;
    logic [7:0] seq_count;

    int compared   = 0;
    int mismatched = 0;

    coil_sys_reset_sequencer #(
        .ASSERT_CYCLES (A),
        .HOLDOFF_CYCLES(H),
        .SYNC_STAGES   (S)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sw_reset_req(sw_reset_req),
        .sys_reset_n (sys_reset_n),
        .busy        (busy),
        .seq_count   (seq_count)
    );

    always #5 clk = ~clk;

    // Reference model: remaining-time countdowns plus a sample history of req.
    int       m_low;
    int       m_hold;
    bit       m_pend;
    bit       m_sw;
    int       m_cnt;
    bit [S:0] m_hist;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_low  = A;
            m_hold = 0;
            m_pend = 0;
            m_sw   = 0;
            m_cnt  = 0;
            m_hist = '0;
        end else begin
            bit e;
            e = m_hist[S-1] & ~m_hist[S];
            for (int i = S; i > 0; i--)
                m_hist[i] = m_hist[i-1];
            m_hist[0] = sw_reset_req;
            if (m_low > 0) begin
                if (e) m_pend = 1;
                m_low = m_low - 1;
                if (m_low == 0) begin
                    m_hold = H;
                    if (m_sw && m_cnt < 255) m_cnt = m_cnt + 1;
                end
            end else if (m_hold > 0) begin
                m_hold = m_hold - 1;
                if (m_hold == 0) begin
                    if (m_pend || e) begin
                        m_low  = A;
                        m_sw   = 1;
                        m_pend = 0;
                    end
                end else if (e) begin
                    m_pend = 1;
                end
            end else if (e) begin
                m_low = A;
                m_sw  = 1;
            end
        end
    end

    task automatic check(input string name, input logic [9:0] act,
                         input logic [9:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s t=%0t got srn/busy/cnt=%h want %h",
                     name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_low >= 0)
            check("model", {sys_reset_n, busy, seq_count},
                  {m_low == 0, (m_low > 0) || (m_hold > 0), 8'(m_cnt)});
    end

    task automatic drive(input logic rn, input logic rq, input int n);
        #1;
        reset_n      = rn;
        sw_reset_req = rq;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input string name, input logic rn, input logic rq,
                       input int n, input logic srn, input logic bsy,
                       input logic [7:0] cnt);
        drive(rn, rq, n);
        check(name, {sys_reset_n, busy, seq_count}, {srn, bsy, cnt});
    endtask

    typedef struct {
        logic       rn;
        logic       req;
        int         n;
        logic       srn;
        logic       busy;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[21];

    initial begin
        m_low        = -1;
        reset_n      = 1'b0;
        sw_reset_req = 1'b0;

        tbl[0]  = '{1'b0, 1'b0,  2, 1'b0, 1'b1, 8'd0};
        tbl[1]  = '{1'b1, 1'b0,  7, 1'b0, 1'b1, 8'd0};
        tbl[2]  = '{1'b1, 1'b0,  1, 1'b1, 1'b1, 8'd0};
        tbl[3]  = '{1'b1, 1'b0,  3, 1'b1, 1'b1, 8'd0};
        tbl[4]  = '{1'b1, 1'b0,  1, 1'b1, 1'b0, 8'd0};
        tbl[5]  = '{1'b1, 1'b1,  2, 1'b1, 1'b0, 8'd0};
        tbl[6]  = '{1'b1, 1'b1,  1, 1'b0, 1'b1, 8'd0};
        tbl[7]  = '{1'b1, 1'b1,  7, 1'b0, 1'b1, 8'd0};
        tbl[8]  = '{1'b1, 1'b1,  1, 1'b1, 1'b1, 8'd1};
        tbl[9]  = '{1'b1, 1'b1,  4, 1'b1, 1'b0, 8'd1};
        tbl[10] = '{1'b1, 1'b1, 10, 1'b1, 1'b0, 8'd1};
        tbl[11] = '{1'b1, 1'b0,  3, 1'b1, 1'b0, 8'd1};
        tbl[12] = '{1'b1, 1'b1,  3, 1'b0, 1'b1, 8'd1};
        tbl[13] = '{1'b1, 1'b0,  2, 1'b0, 1'b1, 8'd1};
        tbl[14] = '{1'b1, 1'b1,  5, 1'b0, 1'b1, 8'd1};
        tbl[15] = '{1'b1, 1'b1,  1, 1'b1, 1'b1, 8'd2};
        tbl[16] = '{1'b1, 1'b1,  3, 1'b1, 1'b1, 8'd2};
        tbl[17] = '{1'b1, 1'b1,  1, 1'b0, 1'b1, 8'd2};
        tbl[18] = '{1'b1, 1'b1,  8, 1'b1, 1'b1, 8'd3};
        tbl[19] = '{1'b1, 1'b1,  4, 1'b1, 1'b0, 8'd3};
        tbl[20] = '{1'b1, 1'b0,  3, 1'b1, 1'b0, 8'd3};

        for (int i = 0; i < 21; i++)
            run($sformatf("vec%0d", i), tbl[i].rn, tbl[i].req, tbl[i].n,
                tbl[i].srn, tbl[i].busy, tbl[i].cnt);

        // five edges across one sequence collapse into one extra sequence
        run("multi_trig", 1'b1, 1'b1, 3, 1'b0, 1'b1, 8'd3);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1);
            drive(1'b1, 1'b1, 1);
        end
        run("multi_done", 1'b1, 1'b0, 30, 1'b1, 1'b0, 8'd5);

        // reset mid-ASSERT with pending set
        run("rst_trig", 1'b1, 1'b1, 3, 1'b0, 1'b1, 8'd5);
        drive(1'b1, 1'b0, 1);
        drive(1'b1, 1'b1, 3);
        run("rst_hold", 1'b0, 1'b0, 1, 1'b0, 1'b1, 8'd0);
        run("rst_low", 1'b1, 1'b0, 7, 1'b0, 1'b1, 8'd0);
        run("rst_rel", 1'b1, 1'b0, 1, 1'b1, 1'b1, 8'd0);
        run("rst_hof", 1'b1, 1'b0, 3, 1'b1, 1'b1, 8'd0);
        run("rst_idle", 1'b1, 1'b0, 1, 1'b1, 1'b0, 8'd0);
        run("rst_stay", 1'b1, 1'b0, 6, 1'b1, 1'b0, 8'd0);

        // back-to-back sequences saturate the counter
        repeat (800) begin
            drive(1'b1, 1'b1, 2);
            drive(1'b1, 1'b0, 2);
        end
        run("sat", 1'b1, 1'b0, 40, 1'b1, 1'b0, 8'd255);

        // edge arriving on the final HOLDOFF cycle
        run("fin_trig", 1'b1, 1'b1, 3, 1'b0, 1'b1, 8'd255);
        drive(1'b1, 1'b0, 7);
        run("fin_hof", 1'b1, 1'b0, 1, 1'b1, 1'b1, 8'd255);
        drive(1'b1, 1'b0, 1);
        run("fin_wait", 1'b1, 1'b1, 2, 1'b1, 1'b1, 8'd255);
        run("fin_edge", 1'b1, 1'b1, 1, 1'b0, 1'b1, 8'd255);
        run("fin_end", 1'b1, 1'b0, 20, 1'b1, 1'b0, 8'd255);

        // random traffic with occasional resets, checked by the model
        repeat (250) begin
            if ($urandom_range(0, 19) == 0)
                drive(1'b0, 1'($urandom_range(0, 1)), $urandom_range(1, 2));
            drive(1'b1, 1'($urandom_range(0, 1)), $urandom_range(1, 15));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
